filter_sequencer: RTL and testbench

FILTER_SEQUENCER -- requirements
Module: filter_sequencer

---
 rtl/filter_sequencer_pkg.sv | 29 ++
 rtl/filter_sequencer_counter.sv | 39 +++
 rtl/filter_sequencer.sv | 146 ++++++++++++++
 tb/tb_filter_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sequencer_pkg.sv
// Shared filter package.
// Holds the sequencer state encoding, the default address/length widths and
// the common filter sizing constants used across the filter datapath.
// Ports: none (package).
package filter_sequencer_pkg;

  localparam int BYTE              = 8;
  localparam int DEFAULT_ADDR_BITS = 9;
  localparam int DEFAULT_LEN_BITS  = 16;
  localparam int INPUT_SIZE        = 2 ** DEFAULT_ADDR_BITS;
  localparam int MAX_N             = 2 ** BYTE - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_RUN     = 3'd2,
    ST_FETCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_t;

  // A frame is unusable when it is empty or larger than the output memory.
  function automatic logic len_out_of_range(input int unsigned len,
                                            input int unsigned limit);
    return (len == 0) || (len > limit);
  endfunction

endpackage

// File: rtl/filter_sequencer_counter.sv
// Shared up-counter used as the byte index of the sequencer.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset, forces count to zero
//   clr        - synchronous clear (wins over en)
//   en         - increment by one
//   count      - registered count value
//   count_next - value count will take on the next edge
module filter_sequencer_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  // Next value is exposed so the owner can register outputs derived from it.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/filter_sequencer.sv
// Filter sequencer: on start, validates the frame length w*h, lets the kernel
// address handler run until it has written len results, then streams the
// output memory to the UART one byte at a time in address order.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-low reset
//   start         - one-cycle request to filter and transmit one frame
//   abort         - cancel the current operation, back to idle next edge
//   w, h          - frame width/height, sampled when start is accepted
//   kernel_w_addr - kernel address handler write pointer
//   tx_done       - one-cycle UART transmit-complete strobe
//   run_kernel    - enables the kernel, steers memory address mux to it
//   rd_addr       - output memory read address while transmitting
//   tx_dv         - one-cycle UART transmit start
//   busy          - sequencer is not idle
//   done          - one-cycle frame-complete pulse
//   err           - sticky bad-length flag, cleared by the next start
// All outputs are registered; they are computed from the next state.
module filter_sequencer
  import filter_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int LEN_BITS  = DEFAULT_LEN_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BYTE-1:0]      w,
  input  logic [BYTE-1:0]      h,
  input  logic [ADDR_BITS-1:0] kernel_w_addr,
  input  logic                 tx_done,
  output logic                 run_kernel,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 tx_dv,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  seq_state_t state;
  seq_state_t next_state;

  logic [LEN_BITS-1:0]  len;
  logic [LEN_BITS-1:0]  len_d;
  logic [LEN_BITS-1:0]  index;
  logic [LEN_BITS-1:0]  index_next;
  logic                 index_clr;
  logic                 index_en;
  logic                 last_byte;
  logic                 kernel_done;
  logic                 len_bad;
  logic                 err_d;
  logic                 run_kernel_d;
  logic                 tx_dv_d;
  logic                 busy_d;
  logic                 done_d;
  logic [ADDR_BITS-1:0] rd_addr_d;

  assign last_byte   = (index == len - LEN_BITS'(1));
  assign kernel_done = (LEN_BITS'(kernel_w_addr) == len);
  assign len_bad     = len_out_of_range(32'(len), 32'd1 << ADDR_BITS);

  // Index restarts at zero when the kernel finishes and whenever the
  // sequencer heads back to idle, so an aborted frame never leaks into the next.
  assign index_clr = (next_state == ST_IDLE) || (state == ST_RUN);
  assign index_en  = (state == ST_WAIT_TX) && tx_done && !abort && !last_byte;

  filter_sequencer_counter #(
    .WIDTH(LEN_BITS)
  ) u_index_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (index_clr),
    .en        (index_en),
    .count     (index),
    .count_next(index_next)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      err        <= 1'b0;
      run_kernel <= 1'b0;
      tx_dv      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_addr    <= '0;
    end else begin
      state      <= next_state;
      len        <= len_d;
      err        <= err_d;
      run_kernel <= run_kernel_d;
      tx_dv      <= tx_dv_d;
      busy       <= busy_d;
      done       <= done_d;
      rd_addr    <= rd_addr_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) next_state = ST_CHECK;
        ST_CHECK:   next_state = len_bad ? ST_IDLE : ST_RUN;
        ST_RUN:     if (kernel_done) next_state = ST_FETCH;
        ST_FETCH:   next_state = ST_SEND;
        ST_SEND:    next_state = ST_WAIT_TX;
        ST_WAIT_TX: if (tx_done) next_state = last_byte ? ST_DONE : ST_FETCH;
        ST_DONE:    next_state = ST_IDLE;
        default:    next_state = ST_IDLE;
      endcase
    end
  end

  // Output values for the next cycle, derived from next_state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    len_d = len;
    err_d = err;
    if (!abort) begin
      if (state == ST_IDLE && start) begin
        len_d = LEN_BITS'(w) * LEN_BITS'(h);
        err_d = 1'b0;
      end
      if (state == ST_CHECK && len_bad) begin
        err_d = 1'b1;
      end
    end
    run_kernel_d = (next_state == ST_RUN);
    tx_dv_d      = (next_state == ST_SEND);
    busy_d       = (next_state != ST_IDLE);
    done_d       = (next_state == ST_DONE);
    rd_addr_d    = '0;
    if (next_state inside {ST_FETCH, ST_SEND, ST_WAIT_TX}) begin
      rd_addr_d = ADDR_BITS'(index_next);
    end
  end

endmodule

// File: tb/tb_filter_sequencer.sv
// Testbench for filter_sequencer.
// Stimulus pushes the expected bytes/done/err events into a scoreboard queue;
// a monitor pops and compares whenever the DUT shows tx_dv, done or a rising err.
// A small UART model answers every tx_dv with a tx_done two cycles later.
module tb_filter_sequencer;
  import filter_sequencer_pkg::*;

  localparam int ADDR_BITS = 9;
  localparam int LEN_BITS  = 16;

  typedef enum int {EV_BYTE = 0, EV_DONE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       value;
  } ev_t;

  typedef enum int {SC_NOMINAL, SC_BADLEN, SC_ABORT, SC_STRAY, SC_RESET} sc_kind_t;
  typedef struct {
    string    name;
    sc_kind_t kind;
    int       w;
    int       h;
    int       len;
    int       cut;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [7:0]           w = '0;
  logic [7:0]           h = '0;
  logic [ADDR_BITS-1:0] kernel_w_addr = '0;
  logic                 resp_tx_done = 1'b0;
  logic                 stray_tx_done = 1'b0;
  logic                 tx_done;
  logic                 run_kernel;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 tx_dv;
  logic                 busy;
  logic                 done;
  logic                 err;

  ev_t  sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vecs[8];

  assign tx_done = resp_tx_done | stray_tx_done;

  filter_sequencer #(
    .ADDR_BITS(ADDR_BITS),
    .LEN_BITS (LEN_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .w            (w),
    .h            (h),
    .kernel_w_addr(kernel_w_addr),
    .tx_done      (tx_done),
    .run_kernel   (run_kernel),
    .rd_addr      (rd_addr),
    .tx_dv        (tx_dv),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input ev_kind_t kind, input int value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic scoreboardPop(input ev_kind_t kind, input logic [31:0] value);
    ev_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL sb_unexpected: got event %0d value %0d, expected none",
               int'(kind), value);
    end else begin
      e = sb_q.pop_front();
      checkOutput("sb_kind", int'(kind), int'(e.kind));
      if (e.kind == EV_BYTE && kind == EV_BYTE) begin
        checkOutput("sb_rd_addr", value, e.value);
      end
    end
  endtask

  // Monitor: compares every observable event against the scoreboard.
  initial begin : monitor
    logic prev_tx_dv;
    logic prev_err;
    prev_tx_dv = 1'b0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tx_dv) begin
          checkOutput("tx_dv_single_cycle", prev_tx_dv, 0);
          scoreboardPop(EV_BYTE, rd_addr);
        end
        if (done) scoreboardPop(EV_DONE, 0);
        if (err && !prev_err) scoreboardPop(EV_ERR, 0);
      end
      prev_tx_dv = tx_dv;
      prev_err   = err;
    end
  end

  // UART model: tx_done two cycles after each tx_dv.
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (tx_dv && rst) begin
        repeat (2) @(negedge clk);
        resp_tx_done = 1'b1;
        @(negedge clk);
        resp_tx_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic pulseStart(input int wv, input int hv);
    @(negedge clk);
    w     = 8'(wv);
    h     = 8'(hv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_err_cleared", err, 0);
  endtask

  task automatic rampKernel(input int len, input bit stray);
    int guard;
    guard = 0;
    while (!run_kernel && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("run_kernel_rise", run_kernel, 1);
    for (int i = 0; i <= len; i++) begin
      kernel_w_addr = ADDR_BITS'(i);
      if (stray && i == 3) begin
        start = 1'b1;
        w     = 8'd2;
        h     = 8'd2;
      end
      if (stray && i == 5) stray_tx_done = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      stray_tx_done = 1'b0;
      if (i < len) checkOutput("run_kernel_hold", run_kernel, 1);
    end
    checkOutput("run_kernel_fall", run_kernel, 0);
  endtask

  task automatic waitByte(input int addr);
    int guard;
    guard = 0;
    while (!(tx_dv && rd_addr == ADDR_BITS'(addr)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("byte_reached", (tx_dv && rd_addr == ADDR_BITS'(addr)), 1);
  endtask

  task automatic runFrame(input int wv, input int hv, input int len, input bit stray);
    int guard;
    for (int i = 0; i < len; i++) pushExpect(EV_BYTE, i);
    pushExpect(EV_DONE, 0);
    pulseStart(wv, hv);
    rampKernel(len, stray);
    guard = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("done_seen", done, 1);
    @(negedge clk);
    checkOutput("done_single_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    checkOutput("err_after_frame", err, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    $display("[TB] scenario %s", v.name);
    case (v.kind)
      SC_NOMINAL, SC_STRAY: begin
        runFrame(v.w, v.h, v.len, v.kind == SC_STRAY);
      end
      SC_BADLEN: begin
        pushExpect(EV_ERR, 0);
        pulseStart(v.w, v.h);
        @(negedge clk);
        checkOutput("badlen_err", err, 1);
        checkOutput("badlen_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
          checkOutput("badlen_no_run", run_kernel, 0);
          @(negedge clk);
        end
        checkOutput("badlen_err_sticky", err, 1);
      end
      SC_ABORT: begin
        for (int i = 0; i <= v.cut; i++) pushExpect(EV_BYTE, i);
        pulseStart(v.w, v.h);
        rampKernel(v.len, 1'b0);
        waitByte(v.cut);
        @(negedge clk);
        checkOutput("abort_wait_rd_addr", rd_addr, v.cut);
        checkOutput("abort_wait_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_tx_dv", tx_dv, 0);
        checkOutput("abort_run_kernel", run_kernel, 0);
        repeat (6) @(negedge clk);
        checkOutput("abort_stays_idle", busy, 0);
        kernel_w_addr = '0;
        runFrame(v.w, v.h, v.len, 1'b0);
      end
      SC_RESET: begin
        for (int i = 0; i <= v.cut; i++) pushExpect(EV_BYTE, i);
        pulseStart(v.w, v.h);
        rampKernel(v.len, 1'b0);
        waitByte(v.cut);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_tx_dv", tx_dv, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_rd_addr", rd_addr, 0);
        checkOutput("async_rst_run_kernel", run_kernel, 0);
        @(negedge clk);
        checkOutput("rst_held_busy", busy, 0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("rst_release_idle", busy, 0);
        checkOutput("rst_release_done", done, 0);
      end
      default: ;
    endcase
    kernel_w_addr = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin : stimulus
    vecs[0] = '{"nominal_4x3",  SC_NOMINAL, 4,  3,  12,   0};
    vecs[1] = '{"badlen_0x5",   SC_BADLEN,  0,  5,  0,    0};
    vecs[2] = '{"oversize_32",  SC_BADLEN,  32, 32, 1024, 0};
    vecs[3] = '{"abort_at_5",   SC_ABORT,   4,  3,  12,   5};
    vecs[4] = '{"stray_in_run", SC_STRAY,   4,  3,  12,   0};
    vecs[5] = '{"reset_in_send", SC_RESET,  4,  3,  12,   2};
    vecs[6] = '{"single_1x1",   SC_NOMINAL, 1,  1,  1,    0};
    vecs[7] = '{"nominal_2x3",  SC_NOMINAL, 2,  3,  6,    0};

    repeat (2) @(negedge clk);
    checkOutput("reset_run_kernel", run_kernel, 0);
    checkOutput("reset_tx_dv", tx_dv, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
